multicycle_alu_ctrl: RTL and testbench



---
 rtl/multicycle_alu_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_alu_ctrl_alu_op_decode.sv | 44 ++++
 rtl/multicycle_alu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_alu_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: ALU function codes,
// opcode values, state encoding and datapath select encodings.
package multicycle_alu_ctrl_pkg;

  localparam int OPCODE_WIDTH = 7;
  localparam int ALU_OP_WIDTH = 4;

  // FSM states; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_JMP  = 3'd6,
    S_HALT = 3'd7
  } state_t;

  // ALU function codes; must match the ALU's decoder.
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_ADD   = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_SUB   = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_LLS   = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_LRS   = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_XOR   = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_OR    = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_AND   = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_GREAT = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] FUNC_ZERO  = 4'd15;

  // Major opcodes (RV32I encoding).
  localparam logic [OPCODE_WIDTH-1:0] OP_R      = 7'h33;
  localparam logic [OPCODE_WIDTH-1:0] OP_I      = 7'h13;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'h6F;
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'h67;
  localparam logic [OPCODE_WIDTH-1:0] OP_ECALL  = 7'h73;

  // Datapath mux encodings.
  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_RS1    = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MDR       = 2'd1;
  localparam logic [1:0] WB_PC        = 2'd2;

  // Branch decision from funct3 and the ALU zero flag.
  // BEQ/BGE/BGEU take on zero; BNE/BLT/BLTU take on non-zero.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic bcond);
    case (funct3)
      3'b000, 3'b101, 3'b111: branch_taken = bcond;
      3'b001, 3'b100, 3'b110: branch_taken = !bcond;
      default:                branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu_ctrl_alu_op_decode.sv
// Combinational ALU function select from state and instruction fields.
module multicycle_alu_ctrl_alu_op_decode
  import multicycle_alu_ctrl_pkg::*;
(
  input  state_t                  state,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7_b5,
  output logic [ALU_OP_WIDTH-1:0] alu_op
);

  logic is_r;
  logic is_alu;

  assign is_r   = (opcode == OP_R);
  assign is_alu = is_r || (opcode == OP_I);

  // Only EX (R/I-ALU) and BR depend on instruction fields; IF/ID always add.
  always_comb begin
    alu_op = FUNC_ZERO;
    case (state)
      S_IF, S_ID: alu_op = FUNC_ADD;
      S_EX: begin
        if (is_alu) begin
          case (funct3)
            3'b000:  alu_op = (is_r && funct7_b5) ? FUNC_SUB : FUNC_ADD;
            3'b001:  alu_op = FUNC_LLS;
            3'b100:  alu_op = FUNC_XOR;
            3'b101:  alu_op = FUNC_LRS;  // arithmetic shift not supported
            3'b110:  alu_op = FUNC_OR;
            3'b111:  alu_op = FUNC_AND;
            default: alu_op = FUNC_ZERO;
          endcase
        end else begin
          alu_op = FUNC_ADD;  // address / JALR target
        end
      end
      // Equality branches subtract; ordered branches use the unsigned compare.
      S_BR:    alu_op = (funct3[2:1] == 2'b00) ? FUNC_SUB : FUNC_GREAT;
      default: alu_op = FUNC_ZERO;
    endcase
  end

endmodule

// File: rtl/multicycle_alu_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EX/MEM/WB (plus BR, JMP and
// HALT) and drives the ALU, register file, PC and memory controls.
// Optional macro ALU_CTRL_PERF_EN adds cycle_count and retired_count outputs.
module multicycle_alu_ctrl
  import multicycle_alu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH,
  parameter int ALU_OP_W = ALU_OP_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  input  logic                alu_bcond,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                pc_write,
  output logic                pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                halted,
`ifdef ALU_CTRL_PERF_EN
  output logic [31:0]         cycle_count,
  output logic [31:0]         retired_count,
`endif
  output logic [2:0]          state
);

  state_t                state_q;
  state_t                next_state;
  logic [OPCODE_W-1:0]   opcode;
  logic [2:0]            funct3;
  logic                  is_load;
  logic [ALU_OP_W-1:0]   dec_alu_op;
  logic                  unused_instr_bits;

  assign opcode            = instr[OPCODE_W-1:0];
  assign funct3            = instr[14:12];
  assign is_load           = (opcode == OP_LOAD);
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign state             = state_q;

  multicycle_alu_ctrl_alu_op_decode u_alu_op_decode (
    .state     (state_q),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (instr[30]),
    .alu_op    (dec_alu_op)
  );

  // Reset forces the ALU to its idle function alongside the other outputs.
  assign alu_op = reset ? FUNC_ZERO : dec_alu_op;

  // State register with synchronous reset to IF.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= next_state;
  end

  // Next-state and Moore output decode; everything idle while reset is high.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    next_state = state_q;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALUOUT;
    halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_ID;
          end
        end
        S_ID: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR: next_state = S_EX;
            OP_BRANCH: next_state = S_BR;
            OP_JAL:    next_state = S_JMP;
            OP_ECALL:  next_state = S_HALT;
            default:   next_state = S_IF;  // unknown opcode retires as a NOP
          endcase
        end
        S_EX: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = (opcode == OP_R) ? SRC_B_RS2 : SRC_B_IMM;
          case (opcode)
            OP_R, OP_I:        next_state = S_WB;
            OP_LOAD, OP_STORE: next_state = S_MEM;
            OP_JALR: begin
              // Link uses the PC before this edge's update.
              pc_write   = 1'b1;
              reg_write  = 1'b1;
              wb_sel     = WB_PC;
              next_state = S_IF;
            end
            default: next_state = S_IF;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_load;
          mem_write = !is_load;
          if (mem_ready) next_state = is_load ? S_WB : S_IF;
        end
        S_WB: begin
          reg_write  = 1'b1;
          wb_sel     = is_load ? WB_MDR : WB_ALUOUT;
          next_state = S_IF;
        end
        S_BR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          pc_source  = 1'b1;
          pc_write   = branch_taken(funct3, alu_bcond);
          next_state = S_IF;
        end
        S_JMP: begin
          reg_write  = 1'b1;
          wb_sel     = WB_PC;
          pc_write   = 1'b1;
          pc_source  = 1'b1;
          next_state = S_IF;
        end
        S_HALT: halted = 1'b1;
        default: next_state = S_IF;
      endcase
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic retire;

  // An instruction retires when a completing state hands back to IF.
  assign retire = !reset && (next_state == S_IF) &&
                  (state_q inside {S_EX, S_MEM, S_WB, S_BR, S_JMP});

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (state_q != S_HALT) cycle_count <= cycle_count + 32'd1;
      if (retire)            retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_alu_ctrl.sv
// Self-checking bench for multicycle_alu_ctrl: directed scenarios followed by
// random instruction streams with random memory stalls.
module tb_multicycle_alu_ctrl;
  import multicycle_alu_ctrl_pkg::*;

  typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_NOP, K_ECALL} kind_e;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        alu_bcond = 1'b0;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic        pc_write, pc_source, ir_write, i_or_d;
  logic        mem_read, mem_write, reg_write, halted;
  logic [2:0]  state;
`ifdef ALU_CTRL_PERF_EN
  logic [31:0] cycle_count, retired_count;
`endif
  logic [4:0]  en;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cyc = 0;
  int          exp_ret = 0;
  logic [31:0] cur_instr = '0;

  multicycle_alu_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .mem_ready     (mem_ready),
    .alu_bcond     (alu_bcond),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .halted        (halted),
`ifdef ALU_CTRL_PERF_EN
    .cycle_count   (cycle_count),
    .retired_count (retired_count),
`endif
    .state         (state)
  );

  always #5 clk = ~clk;

  assign en = {ir_write, pc_write, mem_read, mem_write, reg_write};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Instruction class from the major opcode.
  function automatic kind_e classify(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LOAD;
      7'h23:   return K_STORE;
      7'h63:   return K_BRANCH;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h73:   return K_ECALL;
      default: return K_NOP;
    endcase
  endfunction

  // Expected ALU function for an R/I-ALU instruction in EX.
  function automatic logic [3:0] model_alu_op(input kind_e k, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'd0:    return (k == K_R && f7b5) ? FUNC_SUB : FUNC_ADD;
      3'd1:    return FUNC_LLS;
      3'd4:    return FUNC_XOR;
      3'd5:    return FUNC_LRS;
      3'd6:    return FUNC_OR;
      3'd7:    return FUNC_AND;
      default: return FUNC_ZERO;
    endcase
  endfunction

  // Random instruction of a random class (valid branch funct3 only).
  function automatic logic [31:0] make_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: begin
        r[6:0] = 7'h63;
        case ($urandom_range(0, 5))
          0:       r[14:12] = 3'd0;
          1:       r[14:12] = 3'd1;
          2:       r[14:12] = 3'd4;
          3:       r[14:12] = 3'd5;
          4:       r[14:12] = 3'd6;
          default: r[14:12] = 3'd7;
        endcase
      end
      5: r[6:0] = 7'h6F;
      6: r[6:0] = 7'h67;
      default: begin
        case ($urandom_range(0, 3))
          0:       r[6:0] = 7'h37;
          1:       r[6:0] = 7'h17;
          2:       r[6:0] = 7'h0F;
          default: r[6:0] = 7'h7F;
        endcase
      end
    endcase
    return r;
  endfunction

  // One clock of stimulus: drive at the falling edge, then check state,
  // halted and (when built in) the performance counters.
  task automatic tick(input logic mr, input logic bc, input state_t exp_st);
    @(negedge clk);
    reset     = 1'b0;
    instr     = cur_instr;
    mem_ready = mr;
    alu_bcond = bc;
    #1;
    check($sformatf("state@%s", exp_st.name()), state, exp_st);
    check($sformatf("halted@%s", exp_st.name()), halted, exp_st == S_HALT);
`ifdef ALU_CTRL_PERF_EN
    check("cycle_count", cycle_count, exp_cyc);
    check("retired_count", retired_count, exp_ret);
`endif
    if (exp_st != S_HALT) exp_cyc++;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = rbit();
      alu_bcond = rbit();
      #1;
      check("rst_en", en, 5'b0);
      check("rst_sel", {alu_src_a, alu_src_b, wb_sel, i_or_d, pc_source}, 8'h0);
      check("rst_op", alu_op, FUNC_ZERO);
      check("rst_halted", halted, 1'b0);
    end
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  // Run one instruction from IF until it hands back to IF.
  task automatic run_instr(input logic [31:0] ins, input int stall_if, input int stall_mem, input logic bc);
    kind_e      k;
    logic [2:0] f3;
    logic       ld, mr, take;
    k  = classify(ins);
    f3 = ins[14:12];
    ld = (k == K_LOAD);
    cur_instr = ins;
    for (int s = 0; s <= stall_if; s++) begin
      mr = (s == stall_if);
      tick(mr, rbit(), S_IF);
      check("if_en", en, {mr, mr, 3'b100});
      check("if_src", {alu_src_a, alu_src_b, i_or_d}, 5'b00_01_0);
      check("if_op", alu_op, FUNC_ADD);
      if (mr) check("if_pcsrc", pc_source, 1'b0);
    end
    tick(rbit(), rbit(), S_ID);
    check("id_en", en, 5'b0);
    check("id_src", {alu_src_a, alu_src_b}, 4'b10_10);
    check("id_op", alu_op, FUNC_ADD);
    case (k)
      K_R, K_I: begin
        tick(rbit(), rbit(), S_EX);
        check("ex_en", en, 5'b0);
        check("ex_src", {alu_src_a, alu_src_b}, {2'd1, (k == K_R) ? 2'd0 : 2'd2});
        check("ex_op", alu_op, model_alu_op(k, f3, ins[30]));
        tick(rbit(), rbit(), S_WB);
        check("wb_en", en, 5'b00001);
        check("wb_sel", wb_sel, 2'd0);
        exp_ret++;
      end
      K_LOAD, K_STORE: begin
        tick(rbit(), rbit(), S_EX);
        check("ex_en", en, 5'b0);
        check("ex_src", {alu_src_a, alu_src_b}, 4'b01_10);
        check("ex_op", alu_op, FUNC_ADD);
        for (int s = 0; s <= stall_mem; s++) begin
          mr = (s == stall_mem);
          tick(mr, rbit(), S_MEM);
          check("mem_en", en, {2'b00, ld, !ld, 1'b0});
          check("mem_iord", i_or_d, 1'b1);
          if (mr && !ld) exp_ret++;
        end
        if (ld) begin
          tick(rbit(), rbit(), S_WB);
          check("wb_en", en, 5'b00001);
          check("wb_sel", wb_sel, 2'd1);
          exp_ret++;
        end
      end
      K_JALR: begin
        tick(rbit(), rbit(), S_EX);
        check("jalr_en", en, 5'b01001);
        check("jalr_src", {alu_src_a, alu_src_b}, 4'b01_10);
        check("jalr_op", alu_op, FUNC_ADD);
        check("jalr_sel", {pc_source, wb_sel}, 3'b0_10);
        exp_ret++;
      end
      K_BRANCH: begin
        take = (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? bc : !bc;
        tick(rbit(), bc, S_BR);
        check("br_en", en, {1'b0, take, 3'b000});
        check("br_src", {alu_src_a, alu_src_b, pc_source}, 5'b01_00_1);
        check("br_op", alu_op, (f3 == 3'd0 || f3 == 3'd1) ? FUNC_SUB : FUNC_GREAT);
        exp_ret++;
      end
      K_JAL: begin
        tick(rbit(), rbit(), S_JMP);
        check("jmp_en", en, 5'b01001);
        check("jmp_sel", {pc_source, wb_sel}, 3'b1_10);
        exp_ret++;
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_cycles(2);

    // Directed instructions.
    run_instr(32'h002081B3, 0, 0, 1'b0);  // ADD
    run_instr(32'h402081B3, 0, 0, 1'b0);  // SUB
    run_instr(32'h0000A183, 0, 3, 1'b0);  // LW, three MEM stalls
    run_instr(32'h00208463, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0);  // BEQ not taken
    run_instr(32'h00209463, 0, 0, 1'b1);  // BNE not taken
    run_instr(32'h00209463, 0, 0, 1'b0);  // BNE taken
    run_instr(32'h0000006F, 1, 0, 1'b0);  // JAL with an IF stall
    run_instr(32'h00008067, 0, 0, 1'b0);  // JALR
    run_instr(32'h00000037, 0, 0, 1'b0);  // LUI: not handled, NOP

    // Random stream with random stalls and flags.
    repeat (60) begin
      run_instr(make_instr(), $urandom_range(0, 2), $urandom_range(0, 2), rbit());
    end

    // Reset asserted in the middle of a stalled store.
    cur_instr = 32'h0020A023;
    tick(1'b1, 1'b0, S_IF);
    tick(1'b0, 1'b0, S_ID);
    tick(1'b0, 1'b0, S_EX);
    tick(1'b0, 1'b0, S_MEM);
    check("sw_memw", mem_write, 1'b1);
    reset_cycles(1);
    check("sw_rst_memw", mem_write, 1'b0);
    tick(1'b0, 1'b0, S_IF);

    // ECALL halts; mem_ready toggling must not wake it.
    run_instr(32'h00000073, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'(i), rbit(), S_HALT);
      check("halt_en", en, 5'b0);
    end
    reset_cycles(2);
    run_instr(32'h002081B3, 0, 0, 1'b0);
    tick(1'b0, 1'b0, S_IF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
